// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared state encoding and address-field positions for the
//             data-cache miss/write-through sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REFILL = 3'd1,
        ST_FILL   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_LSB = 2;
    localparam int SET_LSB    = 4;
    localparam int TAG_LSB    = 12;

endpackage
`default_nettype wire

// File: rtl/dcache_linebuf.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_linebuf
//  Purpose  : Refill line buffer: beat counter plus one register per word.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_linebuf #(
    parameter int LINE_WORDS = 4,
    parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    clr,
    input  logic [31:0]             wdata,
    output logic [BEAT_W-1:0]       beat,
    output logic                    last_beat,
    output logic [32*LINE_WORDS-1:0] wm
);

    logic [BEAT_W-1:0]            r_beat;
    logic [LINE_WORDS-1:0][31:0]  r_words;

    // Words are only ever overwritten by a beat; clr rewinds the counter but
    // keeps the previous line visible on wm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat  <= '0;
            r_words <= '0;
        end else if (clr) begin
            r_beat <= '0;
        end else if (we) begin
            r_words[r_beat] <= wdata;
            r_beat          <= r_beat + BEAT_W'(1);
        end
    end

    assign beat      = r_beat;
    assign last_beat = (r_beat == BEAT_W'(LINE_WORDS - 1));
    assign wm        = r_words;

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Load-miss refill and store write-through sequencer with
//             pipeline stall for the 2-way data cache.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_rd,
    input  logic                     req_wr,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic                     cache_hit,
    output logic                     stall,
    output logic                     ready,
    output logic [32*LINE_WORDS-1:0] wm,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic [CNT_W-1:0]         miss_cnt
);
    import dcache_pkg::*;

    localparam int BEAT_W = $clog2(LINE_WORDS);

    state_t             r_state;
    state_t             w_next;
    logic               r_pend_wr;
    logic [31:0]        r_a_q;
    logic [31:0]        r_d_q;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               w_start_refill;
    logic               w_accept;
    logic               w_lb_we;
    logic [BEAT_W-1:0]  w_beat;
    logic               w_last_beat;
    logic               w_unused_lsb;

    assign w_unused_lsb = ^r_a_q[OFFSET_LSB-1:0];
    assign w_accept     = (r_state == ST_IDLE) && (w_next != ST_IDLE);
    assign miss_cnt     = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pend_wr  <= 1'b0;
            r_a_q      <= '0;
            r_d_q      <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a_q <= addr;
                r_d_q <= wdata;
            end
            if (w_start_refill) begin
                r_pend_wr <= req_wr;
                if (r_miss_cnt != '1)
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end else if ((r_state == ST_WRITE) && mem_ack) begin
                r_pend_wr <= 1'b0;
            end
        end
    end

    // Memory outputs decode straight from registered state so that an
    // asynchronous reset drops the request immediately.
    always_comb begin
        w_next         = r_state;
        w_start_refill = 1'b0;
        w_lb_we        = 1'b0;
        stall          = 1'b0;
        ready          = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (r_state)
            ST_IDLE: begin
                stall = req_wr | (req_rd & ~cache_hit);
                if (req_wr) begin
                    if (cache_hit) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next         = ST_REFILL;
                        w_start_refill = 1'b1;
                    end
                end else if (req_rd && !cache_hit) begin
                    w_next         = ST_REFILL;
                    w_start_refill = 1'b1;
                end
            end
            ST_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_a_q[31:SET_LSB], w_beat, OFFSET_LSB'(0)};
                if (mem_ack) begin
                    w_lb_we = 1'b1;
                    if (w_last_beat)
                        w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                stall  = 1'b1;
                ready  = 1'b1;
                w_next = r_pend_wr ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_a_q[31:OFFSET_LSB], OFFSET_LSB'(0)};
                mem_wdata = r_d_q;
                if (mem_ack)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    dcache_linebuf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_linebuf (
        .clk       (clk),
        .rst       (rst),
        .we        (w_lb_we),
        .clr       (w_start_refill),
        .wdata     (mem_rdata),
        .beat      (w_beat),
        .last_beat (w_last_beat),
        .wm        (wm)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Self-checking bench for dcache_ctrl: directed table, random
//             requests against a transaction-level model, reset corner case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int TB_CNT_W = 3;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_rd, req_wr, cache_hit, mem_ack;
    logic [31:0]         addr, wdata, mem_rdata, mem_addr, mem_wdata;
    logic                stall, ready, mem_req, mem_we;
    logic [127:0]        wm;
    logic [TB_CNT_W-1:0] miss_cnt;

    always #5 clk = ~clk;

    dcache_ctrl #(
        .LINE_WORDS (4),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .addr      (addr),
        .wdata     (wdata),
        .cache_hit (cache_hit),
        .stall     (stall),
        .ready     (ready),
        .wm        (wm),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .miss_cnt  (miss_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hit;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        int          exp_stall;
    } vec_t;

    txn_t         got_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           lat_cur  = 1;
    int           acc      = 0;
    int           ready_cnt;
    logic         unstable;
    logic [64:0]  prev_req;
    logic [127:0] wm_at_ready;
    logic [127:0] exp_wm  = '0;
    int           exp_miss = 0;
    logic         nx_rd, nx_wr, nx_hit;
    logic [31:0]  nx_addr, nx_wdata;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int model_stall(input logic rd, input logic wr, input logic hit, input int lat);
        if (wr)
            return 1 + (hit ? 0 : 4 * lat + 1) + lat;
        if (rd && !hit)
            return 4 * lat + 2;
        return 0;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: apply next inputs and play memory at the negedge, sample 1ns later.
    task automatic step();
        @(negedge clk);
        req_rd    = nx_rd;
        req_wr    = nx_wr;
        cache_hit = nx_hit;
        addr      = nx_addr;
        wdata     = nx_wdata;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (acc > 0 && {mem_we, mem_addr, mem_wdata} !== prev_req)
                unstable = 1'b1;
            prev_req = {mem_we, mem_addr, mem_wdata};
            acc++;
            if (acc >= lat_cur) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                got_q.push_back('{mem_we, mem_addr, mem_wdata});
                acc = 0;
            end
        end else begin
            acc     = 0;
            mem_ack = ($urandom_range(0, 1) == 1);
        end
        #1;
        if (ready) begin
            ready_cnt++;
            wm_at_ready = wm;
        end
    endtask

    task automatic idle_steps(input int n);
        nx_rd = 1'b0; nx_wr = 1'b0; nx_hit = 1'($urandom_range(0, 1));
        nx_addr = $urandom; nx_wdata = $urandom;
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_quiet", {stall, mem_req, ready}, 3'b000);
        end
        check("idle_wm_held", wm, exp_wm);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic hit,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat, input int exp_stall);
        txn_t        exp_q[$];
        int          stalls;
        int          guard;
        logic        miss;
        logic [31:0] base;
        got_q.delete();
        ready_cnt = 0;
        unstable  = 1'b0;
        lat_cur   = lat;
        miss      = (rd | wr) & ~hit;
        base      = {a[31:4], 4'h0};
        if (miss) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
                exp_wm[32 * i +: 32] = mem_word(base + 32'(4 * i));
            end
            if (exp_miss < CNT_MAX)
                exp_miss++;
        end
        if (wr)
            exp_q.push_back('{1'b1, {a[31:2], 2'b00}, d});
        if (exp_stall < 0)
            exp_stall = model_stall(rd, wr, hit, lat);

        nx_rd = rd; nx_wr = wr; nx_hit = hit; nx_addr = a; nx_wdata = d;
        stalls = 0;
        guard  = 0;
        step();
        while (stall && guard < 1000) begin
            stalls++;
            guard++;
            nx_addr  = $urandom;
            nx_wdata = $urandom;
            nx_hit   = 1'($urandom_range(0, 1));
            step();
        end
        if (guard >= 1000)
            check("stall_timeout", 1'b1, 1'b0);

        check("stall_cycles", stalls, exp_stall);
        check("txn_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("txn", {got_q[i].we, got_q[i].a, got_q[i].we ? got_q[i].d : 32'h0},
                         {exp_q[i].we, exp_q[i].a, exp_q[i].d});
        check("ready_pulses", ready_cnt, miss ? 1 : 0);
        if (miss)
            check("wm_at_ready", wm_at_ready, exp_wm);
        check("miss_cnt", miss_cnt, exp_miss);
        check("req_stable", unstable, 1'b0);
        idle_steps(2);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,          5,  0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,          20, 82};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hDEADBEEF,   5,  6};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_2008, 32'h1234_5678,  2,  12};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          1,  6};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D,  1,  2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0,          3,  0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'hA5A5_5A5A,  1,  7};

        rst = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; cache_hit = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        nx_rd = 1'b0; nx_wr = 1'b0; nx_hit = 1'b0; nx_addr = '0; nx_wdata = '0;
        ready_cnt = 0;
        step();
        step();
        check("reset_outputs", {stall, ready, mem_req, mem_we, mem_addr, mem_wdata},
              {4'b0000, 64'h0});
        check("reset_wm", wm, 128'h0);
        check("reset_cnt", miss_cnt, 0);
        nx_wr = 1'b1;
        step();
        check("reset_stall_eq", stall, 1'b1);
        nx_wr = 1'b0;
        step();
        #1 rst = 1'b0;
        idle_steps(2);

        for (int i = 0; i < 8; i++)
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].hit, vecs[i].a, vecs[i].d,
                   vecs[i].lat, vecs[i].exp_stall);

        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_req(1'(kind & 1), 1'(kind >> 1), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(1, 6), -1);
        end

        // Reset in the middle of a refill.
        got_q.delete();
        ready_cnt = 0;
        lat_cur   = 3;
        nx_rd = 1'b1; nx_wr = 1'b0; nx_hit = 1'b0; nx_addr = 32'h0000_3450; nx_wdata = '0;
        for (int g = 0; g < 100 && got_q.size() < 3; g++)
            step();
        step();
        #2 rst = 1'b1;
        #1;
        check("rst_ctl", {ready, mem_req, mem_we, stall}, 4'b0001);
        check("rst_mem", {mem_addr, mem_wdata}, 64'h0);
        check("rst_wm", wm, 128'h0);
        check("rst_cnt", miss_cnt, 0);
        nx_rd = 1'b0;
        step();
        check("rst_no_ready", ready_cnt, 0);
        #1 rst = 1'b0;
        exp_wm   = '0;
        exp_miss = 0;
        idle_steps(1);
        do_req(1'b1, 1'b0, 1'b0, 32'h0000_3450, 32'h0, 2, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
